time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Button-driven controller that lets the user set the clock's hours and minutes. It debounces two raw push buttons and runs a RUN → SET_HOUR → SET_MIN mode state machine. It drives increment pulses into the hours/minutes counters, a hold that freezes the seconds counter, a seconds-clear pulse, and blink enables for the 7-segment display. It sits beside the seconds/minutes/hours chain in the clock top level, on the 1 ms clock domain.

## Interface
Parameters:
- DEBOUNCE_MS, 20, consecutive stable cycles required before a button level change is accepted
- HOLD_MS, 500, hold time before auto-repeat starts
- REPEAT_MS, 200, auto-repeat period while ADJ is held
- BLINK_MS, 500, blink half-period
- TIMEOUT_MS, 10000, idle time in a set mode before returning to RUN

Ports:
- clk_1ms  in  1  1 ms system clock; all logic runs on its rising edge
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  raw MODE button, asynchronous, bouncy, 1 = pressed
- btn_adj  in  1  raw ADJ button, asynchronous, bouncy, 1 = pressed
- set_mode  out  2  current state: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
- set_hold  out  1  high in SET_HOUR and SET_MIN; the seconds counter ignores changeSec while this is high
- inc_hour  out  1  one-cycle pulse: hours counter +1, wrapping as in normal counting
- inc_min  out  1  one-cycle pulse: minutes counter +1, wrapping 59→0 with no hour carry
- clr_sec  out  1  one-cycle pulse: seconds counter loads 0
- blink_hour  out  1  1 = blank the hour digits this cycle
- blink_min  out  1  1 = blank the minute digits this cycle

## Operation
- Per button: 2-flop synchronizer, then a debouncer.
  - The debouncer counts cycles in which the synced value differs from the debounced level; the count clears when they agree.
  - When the count reaches DEBOUNCE_MS−1 and the values still differ, the debounced level flips on the next edge.
  - A press event is a registered 0→1 of the debounced level.
- FSM, on MODE press:
  - RUN→SET_HOUR
  - SET_HOUR→SET_MIN
  - SET_MIN→RUN, with clr_sec pulsed in the transition cycle
- ADJ press:
  - in SET_HOUR → inc_hour pulse; in SET_MIN → inc_min pulse
  - ignored in RUN
- Auto-repeat:
  - While ADJ stays debounced-high in a set state, the first repeat pulse occurs HOLD_MS cycles after the press pulse.
  - Further pulses occur every REPEAT_MS cycles.
  - Repeat stops on ADJ release or on any state change.
- Timeout:
  - The idle counter clears on every MODE/ADJ press and every repeat pulse.
  - On reaching TIMEOUT_MS−1 in a set state, the FSM goes to RUN with no clr_sec.
- Blink:
  - A phase bit toggles every BLINK_MS cycles.
  - The phase is forced to 0 (digits visible) on entry to a set state and on every inc pulse.
  - blink_hour = (SET_HOUR & phase); blink_min = (SET_MIN & phase).
- Simultaneous MODE and ADJ press in the same cycle: MODE wins, ADJ is discarded.
- All counters are sized to $clog2(param+1) bits. Counters saturate or clear and never wrap silently.

## Timing
- Reset values:
  - set_mode = RUN
  - all pulse, hold and blink outputs 0
  - debounced levels 0
  - all counters 0
- A button held through reset is seen as a new press after DEBOUNCE_MS.
- Latency: raw input stable high from cycle 0 → inc/mode action visible at cycle DEBOUNCE_MS+3 (2 sync, DEBOUNCE_MS filter, 1 event register).
- Reset mid-operation has priority over every event. No pulse is emitted in the reset cycle or the cycle after.
- The outputs set_mode, set_hold and blink_* are registered and change together with the state register.
- inc_*/clr_sec are high for exactly one cycle per event, with never two pulses in consecutive cycles.

## Structure
- Package clock_pkg holds:
  - typedef enum logic [1:0] set_state_t {RUN, SET_HOUR, SET_MIN}
  - default timing constants
- Sub-module btn_debounce contains the synchronizer, debouncer and press-edge register. It has parameter DEBOUNCE_MS and outputs level and press. It is instantiated once per button.
- FSM, repeat, timeout and blink logic live in time_set_ctrl.

## Test plan
- Reset held 3 cycles, then released with btn_mode=1 → set_mode=0 through cycle DEBOUNCE_MS+2; set_mode=1 at cycle DEBOUNCE_MS+3; set_hold=1.
- Raw btn_mode bouncing 5 times over 8 ms, then stable → exactly one transition RUN→SET_HOUR, 20 cycles after the last bounce plus 3.
- In SET_MIN, ADJ held 1200 ms → inc_min pulses at t=23, 523, 723, 923, 1123 (relative to raw press), then none after release.
- MODE presses ×3 → states 1, 2, 0; clr_sec pulses once, on the SET_MIN→RUN edge only.
- Enter SET_HOUR, no presses for 10000 cycles → set_mode=0 at TIMEOUT_MS−1 after the last press event; clr_sec stays 0.
- In SET_HOUR, raw MODE and ADJ rise in the same cycle → state becomes SET_MIN, inc_hour never pulses; blink_hour=0 throughout SET_MIN.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the clock's time-setting logic.
// All timing values are in 1 ms clock cycles.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } set_state_t;

    localparam int DEBOUNCE_MS_DEF = 20;
    localparam int HOLD_MS_DEF     = 500;
    localparam int REPEAT_MS_DEF   = 200;
    localparam int BLINK_MS_DEF    = 500;
    localparam int TIMEOUT_MS_DEF  = 10000;

    // The MODE button walks RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic set_state_t next_mode(input set_state_t s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counting debouncer and registered press-edge detector
// for one raw push button.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic clk_1ms,
    input  logic reset,
    input  logic btn_i,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every value written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// MODE/ADJ button controller for setting hours and minutes: mode FSM, ADJ
// auto-repeat, idle timeout back to RUN and display blink phase.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int HOLD_MS     = HOLD_MS_DEF,
    parameter int REPEAT_MS   = REPEAT_MS_DEF,
    parameter int BLINK_MS    = BLINK_MS_DEF,
    parameter int TIMEOUT_MS  = TIMEOUT_MS_DEF
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_adj,
    output logic [1:0] set_mode,
    output logic       set_hold,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink_hour,
    output logic       blink_min
);

    localparam int RPT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT_MS + 1);
    localparam int BLINK_W = $clog2(BLINK_MS + 1);

    localparam logic [RPT_W-1:0]   HOLD_LAST    = RPT_W'(HOLD_MS - 1);
    localparam logic [RPT_W-1:0]   REPEAT_LAST  = RPT_W'(REPEAT_MS - 1);
    localparam logic [IDLE_W-1:0]  TIMEOUT_LAST = IDLE_W'(TIMEOUT_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_MS - 1);

    logic mode_level_unused, mode_press, adj_level, adj_press;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_btn (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn_i   (btn_mode),
        .level   (mode_level_unused),
        .press   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_adj_btn (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn_i   (btn_adj),
        .level   (adj_level),
        .press   (adj_press)
    );

    set_state_t         state_q, state_d;
    logic               rpt_on_q, rpt_on_d, rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d, idle_inc;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               set_hold_q, set_hold_d;
    logic               inc_hour_q, inc_hour_d, inc_min_q, inc_min_d, clr_sec_q, clr_sec_d;
    logic               blink_hour_q, blink_hour_d, blink_min_q, blink_min_d;
    logic               in_set, rpt_fire, inc_sel;

    always_comb begin
        state_d     = state_q;
        rpt_on_d    = rpt_on_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        idle_d      = '0;
        inc_sel     = 1'b0;
        clr_sec_d   = 1'b0;
        rpt_fire    = 1'b0;
        in_set      = (state_q != RUN);
        idle_inc    = idle_q + IDLE_W'(1);

        // First repeat waits HOLD_MS after the press, later ones REPEAT_MS apart.
        if (rpt_on_q) begin
            if (!adj_level) begin
                rpt_on_d = 1'b0;
            end else if (rpt_cnt_q == (rpt_first_q ? HOLD_LAST : REPEAT_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end

        // MODE outranks ADJ; idle_d stays cleared on every press and repeat.
        if (mode_press) begin
            state_d   = next_mode(state_q);
            rpt_on_d  = 1'b0;
            clr_sec_d = (state_q == SET_MIN);
        end else if (adj_press && in_set) begin
            inc_sel     = 1'b1;
            rpt_on_d    = 1'b1;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (rpt_fire) begin
            inc_sel = 1'b1;
        end else if (in_set) begin
            if (idle_inc == TIMEOUT_LAST) begin
                state_d  = RUN;
                rpt_on_d = 1'b0;
            end else begin
                idle_d = idle_inc;
            end
        end

        inc_hour_d = inc_sel && (state_q == SET_HOUR);
        inc_min_d  = inc_sel && (state_q == SET_MIN);

        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        // Digits stay visible right after entering a set state or adjusting.
        if (inc_sel || ((state_d != RUN) && (state_d != state_q))) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end

        set_hold_d   = (state_d != RUN);
        blink_hour_d = (state_d == SET_HOUR) && phase_d;
        blink_min_d  = (state_d == SET_MIN) && phase_d;
    end

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            state_q      <= RUN;
            rpt_on_q     <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_cnt_q    <= '0;
            idle_q       <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            set_hold_q   <= 1'b0;
            inc_hour_q   <= 1'b0;
            inc_min_q    <= 1'b0;
            clr_sec_q    <= 1'b0;
            blink_hour_q <= 1'b0;
            blink_min_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rpt_on_q     <= rpt_on_d;
            rpt_first_q  <= rpt_first_d;
            rpt_cnt_q    <= rpt_cnt_d;
            idle_q       <= idle_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            set_hold_q   <= set_hold_d;
            inc_hour_q   <= inc_hour_d;
            inc_min_q    <= inc_min_d;
            clr_sec_q    <= clr_sec_d;
            blink_hour_q <= blink_hour_d;
            blink_min_q  <= blink_min_d;
        end
    end

    assign set_mode   = state_q;
    assign set_hold   = set_hold_q;
    assign inc_hour   = inc_hour_q;
    assign inc_min    = inc_min_q;
    assign clr_sec    = clr_sec_q;
    assign blink_hour = blink_hour_q;
    assign blink_min  = blink_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button activity,
// every cycle compared against a timestamp-based behavioural model.
module tb_time_set_ctrl;

    localparam int D     = 20;
    localparam int HOLD  = 500;
    localparam int REP   = 200;
    localparam int BLINK = 500;
    localparam int TMO   = 10000;

    logic       clk_1ms = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_adj  = 1'b0;
    logic [1:0] set_mode;
    logic       set_hold, inc_hour, inc_min, clr_sec, blink_hour, blink_min;

    int n_checks = 0;
    int n_errors = 0;

    time_set_ctrl #(
        .DEBOUNCE_MS (D),
        .HOLD_MS     (HOLD),
        .REPEAT_MS   (REP),
        .BLINK_MS    (BLINK),
        .TIMEOUT_MS  (TMO)
    ) dut (
        .clk_1ms    (clk_1ms),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_adj    (btn_adj),
        .set_mode   (set_mode),
        .set_hold   (set_hold),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .clr_sec    (clr_sec),
        .blink_hour (blink_hour),
        .blink_min  (blink_min)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Model: n = edges since reset released; hist_* = raw level sampled at each edge.
    int n;
    bit hist_m[$];
    bit hist_a[$];
    bit lvl_m, lvl_a, pend_m, pend_a;
    int st;
    bit rpt_on;
    int rpt_next, idle_ref, blink_ref;
    bit e_inc_h, e_inc_m, e_clr;

    function automatic bit sample(input bit is_adj, input int idx);
        if (idx < 1) return 1'b0;
        return is_adj ? hist_a[idx-1] : hist_m[idx-1];
    endfunction

    // True when the D most recent synchronised samples all disagree with lvl.
    function automatic bit settled(input bit is_adj, input bit lvl);
        for (int j = 0; j < D; j++)
            if (sample(is_adj, n - 2 - j) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        n = 0;
        hist_m.delete();
        hist_a.delete();
        lvl_m = 0; lvl_a = 0; pend_m = 0; pend_a = 0;
        st = 0; rpt_on = 0; rpt_next = 0; idle_ref = 0; blink_ref = 0;
        e_inc_h = 0; e_inc_m = 0; e_clr = 0;
    endtask

    task automatic model_step(input bit rst, input bit m, input bit a);
        bit mp, ap, fire, inc;
        if (rst) begin
            model_clear();
            return;
        end
        n++;
        hist_m.push_back(m);
        hist_a.push_back(a);
        mp = pend_m;
        ap = pend_a;
        fire = rpt_on && lvl_a && (n == rpt_next);
        inc = 0;
        e_inc_h = 0; e_inc_m = 0; e_clr = 0;
        if (!lvl_a) rpt_on = 0;
        if (mp) begin
            e_clr = (st == 2);
            st = (st + 1) % 3;
            rpt_on = 0;
            idle_ref = n;
            if (st != 0) blink_ref = n;
        end else if (ap && st != 0) begin
            inc = 1;
            rpt_on = 1;
            rpt_next = n + HOLD;
        end else if (fire) begin
            inc = 1;
            rpt_next = n + REP;
        end else if (st != 0 && (n - idle_ref) == TMO - 1) begin
            st = 0;
            rpt_on = 0;
        end
        if (inc) begin
            idle_ref = n;
            blink_ref = n;
            e_inc_h = (st == 1);
            e_inc_m = (st == 2);
        end
        pend_m = 0;
        pend_a = 0;
        if (settled(1'b0, lvl_m)) begin lvl_m = ~lvl_m; pend_m = lvl_m; end
        if (settled(1'b1, lvl_a)) begin lvl_a = ~lvl_a; pend_a = lvl_a; end
    endtask

    function automatic logic [7:0] exp_vec();
        bit phase;
        phase = (((n - blink_ref) / BLINK) % 2) == 1;
        return {2'(st), st != 0, e_inc_h, e_inc_m, e_clr, (st == 1) && phase, (st == 2) && phase};
    endfunction

    // Event statistics for the directed scenarios.
    logic [1:0] prev_mode = 2'd0;
    int mode_changes, first_change_n, last_change_n, clr_cnt, clr_n;
    int inc_hour_cnt, bad_blink, blink_min_cnt;
    int inc_min_t[$];

    task automatic clear_stats();
        mode_changes = 0; first_change_n = -1; last_change_n = -1;
        clr_cnt = 0; clr_n = -1; inc_hour_cnt = 0; bad_blink = 0; blink_min_cnt = 0;
        inc_min_t.delete();
    endtask

    task automatic step(input bit r, input bit m, input bit a);
        @(negedge clk_1ms);
        reset = r;
        btn_mode = m;
        btn_adj = a;
        @(posedge clk_1ms);
        #1;
        model_step(r, m, a);
        check("outs", {24'd0, set_mode, set_hold, inc_hour, inc_min, clr_sec, blink_hour, blink_min},
              {24'd0, exp_vec()});
        if (set_mode !== prev_mode) begin
            mode_changes++;
            if (first_change_n < 0) first_change_n = n;
            last_change_n = n;
        end
        prev_mode = set_mode;
        if (inc_min) inc_min_t.push_back(n);
        if (inc_hour) inc_hour_cnt++;
        if (clr_sec) begin clr_cnt++; clr_n = n; end
        if (blink_hour && set_mode == 2'd2) bad_blink++;
        if (blink_min) blink_min_cnt++;
    endtask

    task automatic press_release(input bit m, input bit a);
        for (int i = 0; i < 30; i++) step(0, m, a);
        for (int i = 0; i < 30; i++) step(0, 0, 0);
    endtask

    initial begin
        int n_rise;
        int len;
        bit rm, ra;
        bit [7:0] bounce;

        clear_stats();
        model_clear();

        // Reset held with MODE pressed: first transition after D+3 edges.
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        check("rst_mode", set_mode, 0);
        check("rst_hold", set_hold, 0);
        clear_stats();
        for (int i = 0; i < 30; i++) step(0, 1, 0);
        check("t1_mode_edge", last_change_n, D + 3);
        check("t1_changes", mode_changes, 1);
        check("t1_hold", set_hold, 1);
        for (int i = 0; i < 40; i++) step(0, 0, 0);

        // Mid-operation reset, then a bouncy MODE press.
        step(1, 0, 0);
        step(1, 0, 0);
        check("t2_rst_mode", set_mode, 0);
        clear_stats();
        bounce = 8'b0101_1001;
        for (int i = 0; i < 8; i++) step(0, bounce[i], 0);
        n_rise = n + 1;
        for (int i = 0; i < 40; i++) step(0, 1, 0);
        check("t2_changes", mode_changes, 1);
        check("t2_edge", last_change_n - n_rise + 1, D + 3);
        for (int i = 0; i < 40; i++) step(0, 0, 0);

        // SET_MIN, ADJ held 1200 cycles: press pulse then auto-repeat.
        press_release(1, 0);
        check("t3_in_min", set_mode, 2);
        clear_stats();
        n_rise = n + 1;
        for (int i = 0; i < 1200; i++) step(0, 0, 1);
        for (int i = 0; i < 300; i++) step(0, 0, 0);
        check("t3_pulses", inc_min_t.size(), 5);
        for (int k = 0; k < 5 && k < inc_min_t.size(); k++)
            check("t3_pulse_t", inc_min_t[k] - n_rise + 1, (k == 0) ? D + 3 : D + 3 + HOLD + (k - 1) * REP);

        // Three MODE presses from RUN: 1, 2, 0 with one clr_sec on the last.
        step(1, 0, 0);
        step(1, 0, 0);
        clear_stats();
        for (int k = 0; k < 3; k++) begin
            press_release(1, 0);
            check("t4_state", set_mode, (k + 1) % 3);
        end
        check("t4_clr_cnt", clr_cnt, 1);
        check("t4_clr_edge", clr_n, last_change_n);

        // Idle timeout out of SET_HOUR without clr_sec.
        clear_stats();
        for (int i = 0; i < 30; i++) step(0, 1, 0);
        for (int i = 0; i < TMO + 100; i++) step(0, 0, 0);
        check("t5_changes", mode_changes, 2);
        check("t5_timeout", last_change_n - first_change_n, TMO - 1);
        check("t5_mode", set_mode, 0);
        check("t5_clr", clr_cnt, 0);

        // MODE and ADJ together in SET_HOUR: MODE wins, no hour increment.
        press_release(1, 0);
        check("t6_in_hour", set_mode, 1);
        clear_stats();
        for (int i = 0; i < 40; i++) step(0, 1, 1);
        for (int i = 0; i < 1240; i++) step(0, 0, 0);
        check("t6_mode", set_mode, 2);
        check("t6_inc_hour", inc_hour_cnt, 0);
        check("t6_blink_hour", bad_blink, 0);
        check("t6_blink_min_seen", int'(blink_min_cnt > 0), 1);

        // Random segments of held levels, bounce bursts and occasional reset.
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(900, 30);
            rm = ($urandom_range(3, 0) == 0);
            ra = 1'($urandom_range(1, 0));
            if ($urandom_range(29, 0) == 0) begin
                step(1, 0, 0);
                step(1, 0, 0);
            end
            if ($urandom_range(3, 0) == 0)
                for (int b = 0; b < 6; b++) step(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            for (int i = 0; i < len; i++) step(0, rm, ra);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
